// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC scheduler.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC0 = 2'd1,
        MAC1 = 2'd2,
        MAC2 = 2'd3
    } state_e;

    localparam int DEF_COEF0 = 1;
    localparam int DEF_COEF1 = 2;
    localparam int DEF_COEF2 = 3;

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin arbiter: first eligible request at or above ptr_i, wrapping.
// Masked requests are treated as absent; outputs are purely combinational.
module fir_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CW     = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CW-1:0]     ptr_i,
    input  logic [NUM_CH-1:0] mask_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CW-1:0]     grant_idx_o
);

    logic [NUM_CH-1:0] elig;
    logic              found;
    int                j;

    assign elig = req_i & ~mask_i;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = (int'(ptr_i) + k) % NUM_CH;
            if (!found && elig[j]) begin
                found       = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = j[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// One serial 3-tap MAC shared round-robin across NUM_CH sample channels.
// Optional macro FIR_SCHED_FLUSH_EN adds a per-channel history flush input.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 4,
    parameter int COEF0  = DEF_COEF0,
    parameter int COEF1  = DEF_COEF1,
    parameter int COEF2  = DEF_COEF2,
    parameter int RES_W  = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_valid,
`ifdef FIR_SCHED_FLUSH_EN
    input  logic [NUM_CH-1:0]          flush,
`endif
    output logic [NUM_CH-1:0]          in_ready,
    output logic signed [RES_W-1:0]    out_data,
    output logic [ch_w(NUM_CH)-1:0]    out_ch,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int CW = ch_w(NUM_CH);
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [COEF_W-1:0] C0 = COEF_W'(COEF0);
    localparam logic signed [COEF_W-1:0] C1 = COEF_W'(COEF1);
    localparam logic signed [COEF_W-1:0] C2 = COEF_W'(COEF2);

    if (RES_W < DATA_W + COEF_W + 2) begin : g_res_w_check
        $error("fir_mac_scheduler: RES_W must be at least DATA_W+COEF_W+2");
    end

    state_e                    state_q, state_d;
    logic [CW-1:0]             ptr_q, cur_ch_q, grant_idx;
    logic [NUM_CH-1:0]         grant, flush_w;
    logic                      accept;
    logic signed [DATA_W-1:0]  x0_q [NUM_CH];
    logic signed [DATA_W-1:0]  x1_q [NUM_CH];
    logic signed [DATA_W-1:0]  x2_q [NUM_CH];
    logic signed [RES_W-1:0]   acc_q, out_data_q, prod_ext;
    logic [CW-1:0]             out_ch_q;
    logic                      out_valid_q;
    logic signed [DATA_W-1:0]  mul_x;
    logic signed [COEF_W-1:0]  mul_c;
    logic signed [PW-1:0]      prod;

`ifdef FIR_SCHED_FLUSH_EN
    assign flush_w = (state_q == IDLE) ? flush : '0;
`else
    assign flush_w = '0;
`endif

    fir_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (ptr_q),
        .mask_i      (flush_w),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign in_ready  = (state_q == IDLE && !rst) ? grant : '0;
    assign accept    = |in_ready;
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC0;
            MAC0:    state_d = MAC1;
            MAC1:    state_d = MAC2;
            MAC2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The single multiplier walks the taps oldest-first, one per MAC state.
    always_comb begin
        mul_x = x2_q[cur_ch_q];
        mul_c = C0;
        case (state_q)
            MAC1: begin
                mul_x = x1_q[cur_ch_q];
                mul_c = C1;
            end
            MAC2: begin
                mul_x = x0_q[cur_ch_q];
                mul_c = C2;
            end
            default: ;
        endcase
    end

    assign prod     = mul_x * mul_c;
    assign prod_ext = {{(RES_W-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cur_ch_q    <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                x0_q[i] <= '0;
                x1_q[i] <= '0;
                x2_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (flush_w[i]) begin
                            x0_q[i] <= '0;
                            x1_q[i] <= '0;
                            x2_q[i] <= '0;
                        end else if (in_ready[i]) begin
                            x2_q[i] <= x1_q[i];
                            x1_q[i] <= x0_q[i];
                            x0_q[i] <= in_data[i*DATA_W +: DATA_W];
                        end
                    end
                    if (accept) begin
                        cur_ch_q <= grant_idx;
                        ptr_q    <= (grant_idx == CW'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                MAC0: acc_q <= prod_ext;
                MAC1: acc_q <= acc_q + prod_ext;
                MAC2: begin
                    out_data_q  <= acc_q + prod_ext;
                    out_ch_q    <= cur_ch_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler; flush directed test runs when FIR_SCHED_FLUSH_EN is defined.
// Handshake: a sample transfers on a rising edge where in_valid[i] & in_ready[i]; out_valid is an unstallable one-cycle strobe.
module tb_fir_mac_scheduler;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int RES_W  = 18;
    localparam int CW     = 2;
    localparam int W      = CW + RES_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic signed [RES_W-1:0]  out_data;
    logic [CW-1:0]            out_ch;
    logic                     out_valid;
    logic                     busy;
`ifdef FIR_SCHED_FLUSH_EN
    logic [NUM_CH-1:0]        flush;
`endif

    logic [W-1:0] exp_q[$];
    int           acc_cyc_q[$];
    int           cyc     = 0;
    int           acc_cnt = 0;
    int           n_chk   = 0;
    int           n_fail  = 0;

    fir_mac_scheduler #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .COEF_W (4),
        .COEF0  (1),
        .COEF1  (2),
        .COEF2  (3),
        .RES_W  (RES_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef FIR_SCHED_FLUSH_EN
        .flush     (flush),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_busy", int'(busy), 0);
        in_valid = '0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_acc(input int n);
        int start;
        bit done;
        start = acc_cnt;
        done  = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (acc_cnt - start >= n) done = 1'b1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: act=%0d exp=%0d", acc_cnt - start, n);
        end
    endtask

    task automatic send(input int ch, input int d, input bit push, input int exp);
        if (push) exp_q.push_back({CW'(ch), RES_W'(exp)});
        in_data[ch*DATA_W +: DATA_W] = d[DATA_W-1:0];
        in_valid[ch] = 1'b1;
        wait_acc(1);
        in_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: act=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] item;
        int           a;
        if (rst) begin
            acc_cyc_q.delete();
        end else begin
            if (|(in_valid & in_ready)) begin
                acc_cnt++;
                acc_cyc_q.push_back(cyc);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: act ch=%0d data=%0d exp=none", out_ch, out_data);
                end else begin
                    item = exp_q.pop_front();
                    check("out_data", int'(out_data), int'($signed(item[RES_W-1:0])));
                    check("out_ch", int'(out_ch), int'(item[W-1:RES_W]));
                    if (acc_cyc_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL latency: act=no_accept exp=4");
                    end else begin
                        a = acc_cyc_q.pop_front();
                        check("latency", cyc - a, 4);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_valid = '0;
`ifdef FIR_SCHED_FLUSH_EN
        flush    = '0;
`endif
        do_reset();

        // Channel 0 alone: 10, 20, 30.
        send(0, 10, 1'b1, 30);
        send(0, 20, 1'b1, 80);
        send(0, 30, 1'b1, 140);
        drain();

        // Channel 1, full negative scale: sign extension across all RES_W bits.
        do_reset();
        send(1, -128, 1'b1, -384);
        send(1, -128, 1'b1, -640);
        send(1, -128, 1'b1, -768);
        drain();

        // All channels requesting, then ch0/ch1 contending.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_q.push_back({CW'(i), RES_W'((i + 1) * 3)});
            in_data[i*DATA_W +: DATA_W] = 8'(i + 1);
        end
        exp_q.push_back({2'd0, RES_W'(5)});
        exp_q.push_back({2'd1, RES_W'(10)});
        exp_q.push_back({2'd0, RES_W'(6)});
        exp_q.push_back({2'd1, RES_W'(12)});
        in_valid = '1;
        wait_acc(4);
        in_valid = 4'b0011;
        wait_acc(4);
        in_valid = '0;
        drain();

        // Channel isolation.
        do_reset();
        send(0, 5, 1'b1, 15);
        send(0, 5, 1'b1, 25);
        send(3, 7, 1'b1, 21);
        send(0, 0, 1'b1, 15);
        drain();

        // Reset during MAC1 aborts the computation.
        do_reset();
        send(2, 9, 1'b0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(2, 4, 1'b1, 12);
        drain();

`ifdef FIR_SCHED_FLUSH_EN
        // Flush blocks the grant and clears the channel history.
        do_reset();
        send(0, 10, 1'b1, 30);
        send(0, 20, 1'b1, 80);
        drain();
        begin
            int before;
            before = acc_cnt;
            in_data[0 +: DATA_W] = 8'd30;
            flush       = 4'b0001;
            in_valid[0] = 1'b1;
            #1;
            check("flush_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
            flush = '0;
            check("flush_no_accept", acc_cnt - before, 0);
            check("flush_busy", int'(busy), 0);
        end
        send(0, 30, 1'b1, 90);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
